// File: rtl/spi_frame_writer_if.sv
// spi_frame_writer_if: RAM port A write bundle between the SPI frame writer and the frame RAM.
//   ena   : port A enable                (writer -> RAM)
//   wea   : port A write enable          (writer -> RAM)
//   addra : port A write address, AW bits (writer -> RAM)
//   dia   : port A write data, DW bits    (writer -> RAM)
//   stopa : port A full, no write may start (RAM -> writer)
//   acka  : one-cycle write acknowledge     (RAM -> writer)
interface spi_frame_writer_if #(
  parameter int unsigned DW = 41,
  parameter int unsigned AW = 5
);
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;
  logic          stopa;
  logic          acka;

  modport master (
    output ena, wea, addra, dia,
    input  stopa, acka
  );

  modport slave (
    input  ena, wea, addra, dia,
    output stopa, acka
  );
endinterface

// File: rtl/spi_frame_writer.sv
// spi_frame_writer: deserialises an SPI mode-0 stream (MSB first) into DW-bit frames and writes
// each frame to RAM port A at consecutive, wrapping addresses. A one-entry holding register lets
// the next frame shift in while the current one is being written.
//
// Ports:
//   i_clka       : sole clock, shared with RAM port A
//   i_rst        : synchronous active-high reset
//   i_spi_sck    : SPI clock (asynchronous to i_clka)
//   i_spi_mosi   : SPI data, MSB first
//   i_spi_cs_n   : SPI chip select, active low
//   io_ram       : RAM port A (ena/wea/addra/dia out, stopa/acka in)
//   o_busy       : a frame is held and not yet acknowledged
//   o_overflow   : sticky, a completed frame was dropped because the holder was full
//   o_parity_err : sticky, a frame failed odd parity (tied 0 unless SPI_WR_PARITY_EN)
//
// Build option: define SPI_WR_PARITY_EN to require dia[DW-1] == odd parity over dia[DW-2:0];
// failing frames are discarded and flag o_parity_err.
module spi_frame_writer #(
  parameter int unsigned DW          = 41,
  parameter int unsigned AW          = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clka,
  input  logic               i_rst,
  input  logic               i_spi_sck,
  input  logic               i_spi_mosi,
  input  logic               i_spi_cs_n,
  spi_frame_writer_if.master io_ram,
  output logic               o_busy,
  output logic               o_overflow,
  output logic               o_parity_err
);

  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] LastBit = CW'(DW - 1);

  typedef enum logic [1:0] {StIdle, StPend, StWrite} state_e;

  // Pin synchronisers; MSB of each chain is the synchronised copy.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_q;

  logic                   w_sck;
  logic                   w_mosi;
  logic                   w_cs_n;
  logic                   w_sck_rise;

  logic [DW-1:0]          r_shift;
  logic [CW-1:0]          r_cnt;
  logic                   r_done;

  logic [DW-1:0]          r_hold;
  logic [AW-1:0]          r_addr;
  logic                   r_overflow;
  logic                   r_parity_err;

  state_e                 r_state;
  state_e                 w_state_d;

  logic                   w_frame_ok;
  logic                   w_can_load;
  logic                   w_load;
  logic                   w_drop;
  logic                   w_write;

  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_q     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_sck_q     <= w_sck;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_q;

  // Shifter and bit counter. r_done pulses for one cycle once the last bit is in r_shift.
  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cs_n) begin
        // Deselect abandons any partial frame.
        r_cnt <= '0;
      end else if (w_sck_rise) begin
        r_shift <= {r_shift[DW-2:0], w_mosi};
        if (r_cnt == LastBit) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_WR_PARITY_EN
  assign w_frame_ok = (r_shift[DW-1] == ~^r_shift[DW-2:0]);
`else
  assign w_frame_ok = 1'b1;
`endif

  // The holder is free when empty, or on the acknowledge cycle of the write in flight.
  assign w_can_load = (r_state == StIdle) || ((r_state == StWrite) && io_ram.acka);
  assign w_load     = r_done && w_frame_ok && w_can_load;
  assign w_drop     = r_done && w_frame_ok && !w_can_load;

  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_hold     <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold <= r_shift;
      end
      if ((r_state == StWrite) && io_ram.acka) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef SPI_WR_PARITY_EN
  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_parity_err <= 1'b0;
    end else if (r_done && !w_frame_ok) begin
      r_parity_err <= 1'b1;
    end
  end
`else
  assign r_parity_err = 1'b0;
`endif

  // Write FSM: state register.
  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Write FSM: next state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_load) w_state_d = StPend;
      end
      StPend: begin
        if (!io_ram.stopa) w_state_d = StWrite;
      end
      StWrite: begin
        // stopa is deliberately ignored here; only acka ends a write.
        if (io_ram.acka) w_state_d = w_load ? StPend : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Write FSM: outputs.
  always_comb begin
    w_write = 1'b0;
    o_busy  = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StPend:  o_busy = 1'b1;
      StWrite: begin
        w_write = 1'b1;
        o_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign io_ram.ena   = w_write;
  assign io_ram.wea   = w_write;
  assign io_ram.addra = r_addr;
  assign io_ram.dia   = r_hold;

  assign o_overflow   = r_overflow;
  assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_spi_frame_writer.sv
`timescale 1ns/1ps
// Self-checking bench for spi_frame_writer: an SPI master drives frames, a RAM model acks writes,
// and a queue-based reference predicts which frames land at which addresses.
module tb_spi_frame_writer;

  localparam int unsigned DW          = 41;
  localparam int unsigned AW          = 5;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HalfPer     = 4;
`ifdef SPI_WR_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic busy;
  logic overflow;
  logic parity_err;

  spi_frame_writer_if #(.DW(DW), .AW(AW)) ram_if ();

  spi_frame_writer #(
    .DW          (DW),
    .AW          (AW),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .i_clka       (clk),
    .i_rst        (rst),
    .i_spi_sck    (sck),
    .i_spi_mosi   (mosi),
    .i_spi_cs_n   (cs_n),
    .io_ram       (ram_if),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes in order, next address, expected sticky flags.
  logic [AW-1:0] model_addr = '0;
  logic [DW-1:0] exp_d[$];
  logic [AW-1:0] exp_a[$];
  bit            ovf_exp = 1'b0;
  bit            par_exp = 1'b0;

  // Observed writes, captured by the RAM responder on the first cycle of each write.
  logic [DW-1:0] obs_d[$];
  logic [AW-1:0] obs_a[$];
  int            ack_delay  = 2;
  bit            ack_rand   = 1'b0;
  bit            ack_hold   = 1'b0;
  int            resp_err   = 0;
  bit            stopa_rand = 1'b0;
  bit            stopa_force = 1'b0;

  function automatic logic [DW-1:0] mkf(input logic [DW-1:0] f);
    logic [DW-1:0] r;
    r = f;
    if (ParityEn) r[DW-1] = ~^f[DW-2:0];
    return r;
  endfunction

  function automatic bit frame_ok(input logic [DW-1:0] f);
    return !ParityEn || (f[DW-1] == ~^f[DW-2:0]);
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // stopa driver
  initial begin
    ram_if.stopa = 1'b0;
    forever begin
      @(negedge clk);
      ram_if.stopa = stopa_rand ? ($urandom_range(0, 3) == 0) : stopa_force;
    end
  end

  // RAM port A responder
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
    ram_if.acka = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_if.ena && ram_if.wea) begin
        a = ram_if.addra;
        d = ram_if.dia;
        obs_a.push_back(a);
        obs_d.push_back(d);
        dly = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          if (!(ram_if.ena && ram_if.wea) || ram_if.addra !== a || ram_if.dia !== d) resp_err++;
        end
        while (ack_hold) @(negedge clk);
        if (ram_if.ena) begin
          ram_if.acka = 1'b1;
          @(negedge clk);
          ram_if.acka = 1'b0;
          if (ram_if.ena || ram_if.wea) resp_err++;
        end
      end
    end
  end

  task automatic send_frame(input logic [DW-1:0] f, input int nbits);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HalfPer) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[DW-1-i];
      repeat (HalfPer) @(negedge clk);
      sck = 1'b1;
      repeat (HalfPer) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HalfPer) @(negedge clk);
    cs_n = 1'b1;
    repeat (HalfPer) @(negedge clk);
  endtask

  task automatic expect_write(input logic [DW-1:0] f);
    exp_a.push_back(model_addr);
    exp_d.push_back(f);
    model_addr = model_addr + 1'b1;
  endtask

  task automatic send_model(input logic [DW-1:0] f);
    send_frame(f, DW);
    if (frame_ok(f)) expect_write(f);
    else par_exp = 1'b1;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((obs_d.size() < exp_d.size() || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    check_eq({tag, "_nwrites"}, 64'(obs_d.size()), 64'(exp_d.size()));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      check_eq({tag, "_addr"}, 64'(obs_a.pop_front()), 64'(exp_a.pop_front()));
      check_eq({tag, "_data"}, 64'(obs_d.pop_front()), 64'(exp_d.pop_front()));
    end
    obs_a.delete();
    obs_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_addr = '0;
    ovf_exp    = 1'b0;
    par_exp    = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] f1;
    logic [DW-1:0] f2;
    bit            seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ena",   64'(ram_if.ena),   64'd0);
    check_eq("rst_wea",   64'(ram_if.wea),   64'd0);
    check_eq("rst_addra", 64'(ram_if.addra), 64'd0);
    check_eq("rst_dia",   64'(ram_if.dia),   64'd0);
    check_eq("rst_busy",  64'(busy),         64'd0);
    check_eq("rst_ovf",   64'(overflow),     64'd0);
    check_eq("rst_par",   64'(parity_err),   64'd0);

    // Single known frame, ack two cycles after wea.
    ack_rand  = 1'b0;
    ack_delay = 2;
    send_model(mkf(41'h1_2345_6789A));
    drain("single");
    check_eq("single_addra", 64'(ram_if.addra), 64'd1);

    // 33 frames with random acks and stopa: addresses wrap 31 -> 0.
    do_reset();
    ack_rand   = 1'b1;
    stopa_rand = 1'b1;
    for (int n = 0; n < 33; n++) send_model(mkf(rand_frame()));
    stopa_rand = 1'b0;
    drain("wrap");
    check_eq("wrap_addra", 64'(ram_if.addra), 64'(model_addr));
    check_eq("wrap_ovf",   64'(overflow),     64'd0);

    // Partial frame aborted by cs_n, then a full frame.
    send_frame(rand_frame(), 20);
    send_model(mkf(41'h0_0000_000FF));
    drain("partial");
    check_eq("partial_ovf", 64'(overflow),   64'd0);
    check_eq("partial_par", 64'(parity_err), 64'd0);

    // Raw random frames; with parity checking some are rejected.
    for (int n = 0; n < 12; n++) send_model(rand_frame());
    drain("rand");
    check_eq("rand_par", 64'(parity_err), 64'(par_exp));

    // Back-pressure: first frame held, second dropped.
    stopa_force = 1'b1;
    repeat (3) @(negedge clk);
    f1 = mkf(rand_frame());
    f2 = mkf(rand_frame());
    send_frame(f1, DW);
    send_frame(f2, DW);
    repeat (10) @(negedge clk);
    check_eq("ovf_busy",    64'(busy),          64'd1);
    check_eq("ovf_flag",    64'(overflow),      64'd1);
    check_eq("ovf_nowrite", 64'(obs_d.size()),  64'd0);
    expect_write(f1);
    ovf_exp     = 1'b1;
    stopa_force = 1'b0;
    drain("ovf");
    check_eq("ovf_sticky", 64'(overflow), 64'(ovf_exp));

`ifdef SPI_WR_PARITY_EN
    f1 = mkf(rand_frame());
    f1[DW-1] = ~f1[DW-1];
    send_model(f1);
    drain("parbad");
    check_eq("parbad_flag", 64'(parity_err), 64'd1);
    send_model(mkf(rand_frame()));
    drain("pargood");
`endif

    // Reset during a write.
    ack_rand  = 1'b0;
    ack_delay = 0;
    ack_hold  = 1'b1;
    f1 = mkf(rand_frame());
    send_frame(f1, DW);
    expect_write(f1);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (ram_if.ena) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("rstwr_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstwr_ena",   64'(ram_if.ena),   64'd0);
    check_eq("rstwr_wea",   64'(ram_if.wea),   64'd0);
    check_eq("rstwr_addra", 64'(ram_if.addra), 64'd0);
    check_eq("rstwr_busy",  64'(busy),         64'd0);
    check_eq("rstwr_ovf",   64'(overflow),     64'd0);
    check_eq("rstwr_par",   64'(parity_err),   64'd0);
    model_addr = '0;
    ovf_exp    = 1'b0;
    par_exp    = 1'b0;
    ack_hold   = 1'b0;
    ack_delay  = 1;
    send_model(mkf(rand_frame()));
    drain("postrst");

    check_eq("final_ovf",  64'(overflow),   64'(ovf_exp));
    check_eq("final_par",  64'(parity_err), 64'(par_exp));
    check_eq("resp_errs",  64'(resp_err),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
